uart_tx_peripheral: RTL and testbench
=====================================

// Module: uart_tx_peripheral
// PURPOSE
//  Memory-mapped UART transmitter on the peripheral bus, downstream of the address decoder.
//  The CPU writes bytes through the decoder's ce_out/rw_out slot. They queue in a FIFO
//  and are serialised as 8N1 frames on tx. irq feeds one decoder irq_source line.
// PARAMETERS
//  DATA_WIDTH    32   CPU bus width; only [7:0] is transmitted
//  FIFO_DEPTH    8    TX FIFO entries; power of 2, >=2
//  DEFAULT_DIV   87   reset baud divisor in clk cycles per bit (10 MHz / 115200)
//  TX_DATA_ADDR  4'h0 write: push byte
//  TX_STAT_ADDR  4'h1 read: status; write: clear sticky bits
//  TX_DIV_ADDR   4'h2 read/write: baud divisor [15:0]
//  TX_IRQ_ADDR   4'h3 read/write: irq enable bit [0]
// PORTS
//  clk       in   1           system clock, rising edge
//  rst       in   1           synchronous, active-high reset
//  data_in   in   DATA_WIDTH  write data from CPU
//  data_out  out  DATA_WIDTH  read data to CPU
//  address   in   4           register select
//  rw        in   1           1 = write, 0 = read
//  ce        in   1           chip enable from decoder
//  irq       out  1           interrupt request to decoder
//  tx        out  1           serial line, idle high
// BEHAVIOUR
//  - Reset state: tx=1, irq=0, FIFO empty, FSM IDLE, div=DEFAULT_DIV, irq_en=0, overflow=0.
//  - Writes occur on the clk edge when ce=1 and rw=1.
//  - data_out is combinational from address when ce=1 and rw=0, and 0 otherwise.
//  - STATUS read layout:
//      [0] empty, [1] full, [2] busy (FSM != IDLE), [3] overflow (sticky)
//      [7:4] reserved 0, [15:8] FIFO count
//  - Write to TX_DATA with FIFO not full: push data_in[7:0], count+1 on the next cycle.
//  - Full is evaluated before any same-cycle pop. A push while full is dropped and sets overflow.
//  - Write to TX_STAT with data_in[3]=1 clears overflow.
//  - Divisor writes use data_in[15:0]; values <2 are stored as 2.
//    The divisor is latched into the bit timer at frame start, so an in-flight frame is unaffected.
//  - FSM states:
//      IDLE: when FIFO not empty, pop the head into the shift register and go to START.
//            The pop happens in the same cycle.
//      START: tx=0 for div cycles.
//      DATA: 8 bits, LSB first, each held div cycles.
//      STOP: tx=1 for div cycles. Then go to IDLE, or back to START with an immediate pop
//            if the FIFO is not empty (back-to-back frames, no idle gap).
//  - Frame length = 10*div cycles.
//  - Latency: the first start bit asserts on the 2nd clk edge after the write edge
//    (1 cycle push, 1 cycle pop).
//  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  - Count is log2(FIFO_DEPTH)+1 bits.
//  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
//  - rst asserted mid-frame: tx returns to 1 on the next edge, the FIFO is flushed,
//    and all registers take reset values.
//  - Read-only or unmapped addresses ignore writes. Unmapped addresses read 0.
// CONFIGURATION
//  - UART_TX_IRQ_EN defined:
//      irq is registered: irq = irq_en & empty & ~busy, i.e. asserted when the
//      transmitter is fully drained.
//      irq is level-sensitive; it clears by pushing data or writing irq_en=0.
//  - UART_TX_IRQ_EN undefined:
//      irq is tied 0 and the TX_IRQ_ADDR register is absent (reads 0, writes ignored).
// TESTING
//  1. Release reset, read STATUS -> 0x00000001; read DIV -> 87; tx=1.
//  2. Write DIV=4, push 0x55 -> tx sequence: 0, then 1,0,1,0,1,0,1,0, then 1.
//     Each bit lasts 4 cycles (40 cycles total); busy=1 throughout; then STATUS=0x1.
//  3. With tx busy on a long frame, push 9 bytes -> STATUS count=8, full=1, overflow=1.
//     Write STAT with 0x8 -> overflow=0.
//     All 8 queued bytes are sent back-to-back in order.
//  4. Mid-frame write DIV=8 -> the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
//  5. Assert rst during the DATA state with 3 bytes queued -> next edge tx=1, STATUS=0x1,
//     and no further start bits are sent.
//  6. (UART_TX_IRQ_EN) irq_en=1, push 0xA5 -> irq=0 while busy;
//     irq=1 one cycle after STOP ends; push again -> irq=0.

Source files
------------

// File: rtl/uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_peripheral
// Description : Memory-mapped 8N1 UART transmitter with a TX FIFO. The CPU
//               pushes bytes through the decoder slot. A three-process FSM
//               pops them and shifts them out LSB first on tx.
//               Optional drained-interrupt: define UART_TX_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_peripheral #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          DEFAULT_DIV  = 87,
    parameter logic [3:0]  TX_DATA_ADDR = 4'h0,
    parameter logic [3:0]  TX_STAT_ADDR = 4'h1,
    parameter logic [3:0]  TX_DIV_ADDR  = 4'h2,
    parameter logic [3:0]  TX_IRQ_ADDR  = 4'h3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [3:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    output logic                  irq,
    output logic                  tx
);

    localparam int                 c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W       = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]        c_DEFAULT_DIV = 16'(DEFAULT_DIV);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    // Configuration and serialiser state
    logic [15:0]         r_div;
    logic [15:0]         r_frame_div;
    logic [15:0]         r_timer;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_tx;

    logic                w_wr_en;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_busy;
    logic                w_bit_done;
    logic                w_tx_bit;
    logic [15:0]         w_div_wr_val;
    logic [DATA_WIDTH-1:0] w_status;
    logic                w_unused;

    assign w_wr_en      = ce & rw;
    assign w_push_req   = w_wr_en && (address == TX_DATA_ADDR);
    // Full is judged on the pre-pop count, so a push while full is lost
    // even if the serialiser pops in the same cycle.
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_push       = w_push_req & ~w_full;
    assign w_bit_done   = (r_timer == (r_frame_div - 16'd1));
    assign w_div_wr_val = (data_in[15:0] < 16'd2) ? 16'd2 : data_in[15:0];
    assign w_unused     = &{1'b0, data_in[DATA_WIDTH-1:16]};
    assign tx           = r_tx;

    // FIFO payload write (storage needs no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_en && (address == TX_STAT_ADDR) && data_in[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Baud divisor register; tiny values are clamped so a bit lasts >= 2 cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= c_DEFAULT_DIV;
        end else if (w_wr_en && (address == TX_DIV_ADDR)) begin
            r_div <= w_div_wr_val;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (!w_empty) w_state_next = c_START;
            c_START: if (w_bit_done) w_state_next = c_DATA;
            c_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = c_STOP;
            c_STOP:  if (w_bit_done) w_state_next = w_empty ? c_IDLE : c_START;
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM outputs: line level, FIFO pop strobe, busy flag
    always_comb begin
        w_tx_bit = 1'b1;
        w_pop    = 1'b0;
        w_busy   = (r_state != c_IDLE);
        case (r_state)
            c_IDLE:  w_pop = ~w_empty;
            c_START: w_tx_bit = 1'b0;
            c_DATA:  w_tx_bit = r_shift[0];
            c_STOP:  w_pop = w_bit_done & ~w_empty;
            default: w_tx_bit = 1'b1;
        endcase
    end

    // Bit timer and shifter; divisor is captured at each pop so a frame in
    // flight keeps its original bit time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= 8'hFF;
            r_frame_div <= c_DEFAULT_DIV;
        end else if (w_pop) begin
            r_shift     <= r_mem[r_rd_ptr];
            r_frame_div <= r_div;
            r_timer     <= '0;
            r_bit_idx   <= '0;
        end else if (r_state != c_IDLE) begin
            if (w_bit_done) begin
                r_timer <= '0;
                if (r_state == c_DATA) begin
                    r_shift   <= {1'b1, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    // Registered serial line, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_bit;
        end
    end

    // Status word assembly
    always_comb begin
        w_status                = '0;
        w_status[0]             = w_empty;
        w_status[1]             = w_full;
        w_status[2]             = w_busy;
        w_status[3]             = r_overflow;
        w_status[8 +: c_CNT_W]  = r_count;
    end

`ifdef UART_TX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Drained interrupt: level high while enabled and nothing left to send
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && (address == TX_IRQ_ADDR)) begin
                r_irq_en <= data_in[0];
            end
            r_irq <= r_irq_en & w_empty & ~w_busy;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Combinational CPU read mux; zero when not selected for a read
    always_comb begin
        data_out = '0;
        if (ce && !rw) begin
            case (address)
                TX_STAT_ADDR: data_out = w_status;
                TX_DIV_ADDR:  data_out[15:0] = r_div;
`ifdef UART_TX_IRQ_EN
                TX_IRQ_ADDR:  data_out[0] = r_irq_en;
`else
                TX_IRQ_ADDR:  data_out = '0;
`endif
                default:      data_out = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_peripheral
// Description : Self-checking bench for uart_tx_peripheral. Pushed bytes go
//               into a scoreboard queue; a line monitor decodes each frame
//               and compares it against the head of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_peripheral;

    localparam logic [3:0] c_ADDR_DATA = 4'h0;
    localparam logic [3:0] c_ADDR_STAT = 4'h1;
    localparam logic [3:0] c_ADDR_DIV  = 4'h2;
    localparam logic [3:0] c_ADDR_IRQ  = 4'h3;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  address;
    logic        rw;
    logic        ce;
    logic        irq;
    logic        tx;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          cyc           = 0;
    int          last_end      = -10;
    int          n_frames      = 0;
    int          n_b2b         = 0;
    int          m_div         = 87;
    logic [7:0]  sb [$];

    uart_tx_peripheral #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(87)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .data_out(data_out),
        .address (address),
        .rw      (rw),
        .ce      (ce),
        .irq     (irq),
        .tx      (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; rw = 1'b1; address = a; data_in = d;
        @(posedge clk);
        #1;
        ce = 1'b0; rw = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; rw = 1'b0; address = a;
        #1;
        d = data_out;
        ce = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus_write(c_ADDR_DATA, {24'h000000, b});
        if (accepted) sb.push_back(b);
    endtask

    task automatic set_div(input logic [31:0] v);
        bus_write(c_ADDR_DIV, v);
        m_div = (v[15:0] < 16'd2) ? 2 : int'(v[15:0]);
    endtask

    task automatic wait_drain(input int max_polls);
        logic [31:0] s;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < max_polls && !done; i++) begin
            bus_read(c_ADDR_STAT, s);
            if (s == 32'h1 && sb.size() == 0) done = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_value("drain", {31'b0, done}, 32'h1);
    endtask

    // Line monitor: decodes frames and scores them against the queue
    initial begin : p_monitor
        logic [7:0] exp_byte;
        logic [7:0] got_byte;
        logic       exp_bit;
        int         fd;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) continue;
            n_frames++;
            if (cyc == last_end + 1) n_b2b++;
            if (sb.size() == 0) begin
                check_value("unexpected_frame", 32'd1, 32'd0);
                for (int k = 0; k < 4096 && tx === 1'b0; k++) @(negedge clk);
                continue;
            end
            exp_byte = sb.pop_front();
            fd       = m_div;
            bad      = 0;
            got_byte = '0;
            aborted  = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
                for (int c = 0; c < fd && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        exp_bit = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : exp_byte[b-1]);
                        if (tx !== exp_bit) bad++;
                        if (b >= 1 && b <= 8 && c == fd / 2) got_byte[b-1] = tx;
                    end
                end
            end
            if (!aborted) begin
                check_value("frame_data", {24'h0, got_byte}, {24'h0, exp_byte});
                check_value("frame_timing", bad, 32'd0);
                last_end = cyc;
            end
        end
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        logic [31:0] r;
        int          b2b_before;
        int          frames_before;
        rst = 1'b1; ce = 1'b0; rw = 1'b0; address = '0; data_in = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and register access
        @(negedge clk);
        check_value("reset_tx", {31'b0, tx}, 32'h1);
        check_value("reset_irq", {31'b0, irq}, 32'h0);
        check_value("idle_dout", data_out, 32'h0);
        bus_read(c_ADDR_STAT, r);  check_value("reset_stat", r, 32'h1);
        bus_read(c_ADDR_DIV, r);   check_value("reset_div", r, 32'd87);
        bus_read(4'h7, r);         check_value("unmapped_rd", r, 32'h0);
        bus_write(4'h7, 32'hFFFF_FFFF);
        bus_read(c_ADDR_STAT, r);  check_value("unmapped_wr", r, 32'h1);
        set_div(32'd0);
        bus_read(c_ADDR_DIV, r);   check_value("div_clamp0", r, 32'd2);
        set_div(32'd1);
        bus_read(c_ADDR_DIV, r);   check_value("div_clamp1", r, 32'd2);
        set_div(32'hFFFF_0004);
        bus_read(c_ADDR_DIV, r);   check_value("div_low16", r, 32'd4);

        // Single frame 0x55 with first-start-bit latency
        push_byte(8'h55, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_value("lat_edge1", {31'b0, tx}, 32'h1);
        @(negedge clk);
        check_value("lat_edge2", {31'b0, tx}, 32'h0);
        bus_read(c_ADDR_STAT, r);  check_value("busy_stat_a", r, 32'h5);
        repeat (15) @(negedge clk);
        bus_read(c_ADDR_STAT, r);  check_value("busy_stat_b", r, 32'h5);
        wait_drain(200);
        bus_read(c_ADDR_STAT, r);  check_value("after_55", r, 32'h1);

        // Overflow, sticky clear and back-to-back drain
        set_div(32'd20);
        b2b_before = n_b2b;
        push_byte(8'hC3, 1'b1);
        for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i * 8'h11), (i < 8));
        bus_read(c_ADDR_STAT, r);  check_value("full_stat", r, 32'h0000_080E);
        bus_write(c_ADDR_STAT, 32'h7);
        bus_read(c_ADDR_STAT, r);  check_value("ovf_keep", r, 32'h0000_080E);
        bus_write(c_ADDR_STAT, 32'h8);
        bus_read(c_ADDR_STAT, r);  check_value("ovf_clear", r, 32'h0000_0806);
        wait_drain(3000);
        check_value("b2b_frames", n_b2b - b2b_before, 32'd8);

        // Divisor change while a frame is in flight
        set_div(32'd4);
        b2b_before = n_b2b;
        bus_write(c_ADDR_DATA, 32'hDEAD_BE3C);
        sb.push_back(8'h3C);
        push_byte(8'h96, 1'b1);
        repeat (4) @(negedge clk);
        set_div(32'd8);
        bus_read(c_ADDR_DIV, r);   check_value("div_mid", r, 32'd8);
        wait_drain(300);
        check_value("b2b_divchg", n_b2b - b2b_before, 32'd1);

        // Reset in the middle of a data bit with bytes queued
        set_div(32'd4);
        push_byte(8'h00, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("rst_tx", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        m_div = 87;
        sb.delete();
        frames_before = n_frames;
        bus_read(c_ADDR_STAT, r);  check_value("rst_stat", r, 32'h1);
        bus_read(c_ADDR_DIV, r);   check_value("rst_div", r, 32'd87);
        repeat (200) @(negedge clk);
        check_value("no_restart", n_frames - frames_before, 32'd0);
        check_value("rst_tx_idle", {31'b0, tx}, 32'h1);

`ifdef UART_TX_IRQ_EN
        // Drained interrupt
        begin
            bit rose;
            set_div(32'd4);
            bus_write(c_ADDR_IRQ, 32'h1);
            bus_read(c_ADDR_IRQ, r);   check_value("irq_en_rd", r, 32'h1);
            repeat (2) @(negedge clk);
            check_value("irq_idle", {31'b0, irq}, 32'h1);
            push_byte(8'hA5, 1'b1);
            repeat (4) @(negedge clk);
            check_value("irq_busy", {31'b0, irq}, 32'h0);
            rose = 1'b0;
            for (int i = 0; i < 100 && !rose; i++) begin
                @(negedge clk);
                if (irq) rose = 1'b1;
            end
            check_value("irq_rise", {31'b0, rose}, 32'h1);
            check_value("irq_sb_empty", sb.size(), 32'd0);
            push_byte(8'h5A, 1'b1);
            repeat (2) @(negedge clk);
            check_value("irq_push_clr", {31'b0, irq}, 32'h0);
            wait_drain(200);
            bus_write(c_ADDR_IRQ, 32'h0);
            repeat (2) @(negedge clk);
            check_value("irq_dis", {31'b0, irq}, 32'h0);
        end
`else
        bus_write(c_ADDR_IRQ, 32'h1);
        bus_read(c_ADDR_IRQ, r);   check_value("irq_reg_absent", r, 32'h0);
        repeat (2) @(negedge clk);
        check_value("irq_tied", {31'b0, irq}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
